// File: rtl/enc_pkg.sv
// -----------------------------------------------------------------------------
// enc_pkg
// Shared definitions for the quadrature encoder bank:
//   - step_e      : result of decoding one accepted AB level change
//   - decode_step : (previous AB, new AB) -> step_e
//   - read-map helpers giving the shadow-register address layout
// No ports (package).
// -----------------------------------------------------------------------------
package enc_pkg;

    typedef enum logic [1:0] {
        STEP_NONE    = 2'd0,
        STEP_INC     = 2'd1,
        STEP_DEC     = 2'd2,
        STEP_ILLEGAL = 2'd3
    } step_e;

    // Read map: counts start at 0, velocities follow, then err word, then config word.
    localparam int unsigned MAP_CNT_BASE = 0;

    function automatic int unsigned map_vel_base(input int unsigned n_ch);
        return n_ch;
    endfunction

    function automatic int unsigned map_err_addr(input int unsigned n_ch);
        return 2 * n_ch;
    endfunction

    function automatic int unsigned map_cfg_addr(input int unsigned n_ch);
        return 2 * n_ch + 1;
    endfunction

    // Position of an AB level along the forward cycle 00->01->11->10.
    function automatic logic [1:0] gray_pos(input logic [1:0] ab);
        return {ab[1], ab[1] ^ ab[0]};
    endfunction

    // Position difference modulo 4: +1 forward, -1 (3) reverse, 2 means both bits flipped.
    function automatic step_e decode_step(input logic [1:0] prev_ab, input logic [1:0] ab);
        logic [1:0] d;
        d = gray_pos(ab) - gray_pos(prev_ab);
        case (d)
            2'd0:    return STEP_NONE;
            2'd1:    return STEP_INC;
            2'd3:    return STEP_DEC;
            default: return STEP_ILLEGAL;
        endcase
    endfunction

endpackage

// File: rtl/quad_channel.sv
// -----------------------------------------------------------------------------
// quad_channel
// One encoder channel: 2-FF synchroniser, glitch filter, priming, x4 decode,
// signed wrapping counter and sticky illegal-transition flag.
// Ports:
//   clk      in   system clock
//   rst      in   asynchronous active-high reset
//   a_i/b_i  in   raw encoder pins (asynchronous)
//   clear_i  in   1-cycle pulse: zero count and flag, re-prime on current level
//   count_o  out  live signed count (CNT_W)
//   err_o    out  sticky illegal-transition flag
// -----------------------------------------------------------------------------
module quad_channel
    import enc_pkg::*;
#(
    parameter int CNT_W    = 32,
    parameter int FILT_LEN = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    a_i,
    input  logic                    b_i,
    input  logic                    clear_i,
    output logic signed [CNT_W-1:0] count_o,
    output logic                    err_o
);

    localparam int RUN_W = $clog2(FILT_LEN + 1);
    localparam logic [RUN_W-1:0] RUN_FULL = RUN_W'(FILT_LEN);

    logic [1:0]             sync1_q, sync2_q;
    logic [1:0]             sv_q;          // marks sync stages holding real pin samples
    logic [1:0]             last_q, last_d;
    logic [RUN_W-1:0]       run_q, run_d;
    logic [1:0]             prev_q, prev_d;
    logic                   primed_q, primed_d;
    logic signed [CNT_W-1:0] count_q, count_d;
    logic                   err_q, err_d;
    logic                   accept;
    step_e                  step;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q  <= 2'b00;
            sync2_q  <= 2'b00;
            sv_q     <= 2'b00;
            last_q   <= 2'b00;
            run_q    <= '0;
            prev_q   <= 2'b00;
            primed_q <= 1'b0;
            count_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            sync1_q  <= {a_i, b_i};
            sync2_q  <= sync1_q;
            sv_q     <= {sv_q[0], 1'b1};
            last_q   <= last_d;
            run_q    <= run_d;
            prev_q   <= prev_d;
            primed_q <= primed_d;
            count_q  <= count_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        last_d   = last_q;
        run_d    = run_q;
        accept   = 1'b0;
        prev_d   = prev_q;
        primed_d = primed_q;
        count_d  = count_q;
        err_d    = err_q;
        step     = decode_step(prev_q, sync2_q);

        // Samples taken before the synchroniser has filled after reset are
        // reset values, not pin levels, so they are ignored.
        if (sv_q[1]) begin
            last_d = sync2_q;
            if (sync2_q != last_q) begin
                run_d = RUN_W'(1);
            end else if (run_q != RUN_FULL) begin
                run_d = run_q + RUN_W'(1);
            end
            accept = (run_d == RUN_FULL) && ((run_q != RUN_FULL) || (sync2_q != last_q));
        end

        if (accept) begin
            prev_d = sync2_q;
            if (!primed_q) begin
                primed_d = 1'b1;
            end else begin
                case (step)
                    STEP_INC:     count_d = count_q + CNT_W'(1);
                    STEP_DEC:     count_d = count_q - CNT_W'(1);
                    STEP_ILLEGAL: err_d   = 1'b1;
                    default:      ;
                endcase
            end
        end

        // Restarting the filter run makes the current stable level re-accepted,
        // which re-primes the channel without needing pin movement.
        if (clear_i) begin
            run_d    = '0;
            primed_d = 1'b0;
            count_d  = '0;
            err_d    = 1'b0;
        end
    end

    assign count_o = count_q;
    assign err_o   = err_q;

endmodule

// File: rtl/quad_encoder_bank.sv
// -----------------------------------------------------------------------------
// quad_encoder_bank
// N-channel quadrature decoder bank with periodic velocity sampling and a
// coherent shadow snapshot for address-mapped readout.
// Ports:
//   clk          in   system clock
//   reset        in   asynchronous active-high reset
//   enc_a/enc_b  in   raw encoder pins per channel
//   clear        in   per-channel pulse: zero count, velocity, reference, err
//   snap         in   copy live counts/velocities/err into shadows
//   rd_addr      in   shadow read address
//   rd_data      out  shadow word (combinational, sign-extended to 32)
//   err_flags    out  live sticky illegal-transition flags
//   sample_tick  out  1-cycle pulse in the cycle velocities are sampled
// -----------------------------------------------------------------------------
module quad_encoder_bank
    import enc_pkg::*;
#(
    parameter int N_CH       = 4,
    parameter int CNT_W      = 32,
    parameter int FILT_LEN   = 3,
    parameter int PERIOD_CYC = 500000,
    parameter int ADDR_W     = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N_CH-1:0]   enc_a,
    input  logic [N_CH-1:0]   enc_b,
    input  logic [N_CH-1:0]   clear,
    input  logic              snap,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [31:0]       rd_data,
    output logic [N_CH-1:0]   err_flags,
    output logic              sample_tick
);

    localparam int PER_W = $clog2(PERIOD_CYC);
    localparam logic [PER_W-1:0] PER_LAST = PER_W'(PERIOD_CYC - 1);

    logic signed [CNT_W-1:0] cnt   [N_CH];
    logic signed [CNT_W-1:0] vel_q [N_CH];
    logic signed [CNT_W-1:0] vel_d [N_CH];
    logic signed [CNT_W-1:0] ref_q [N_CH];
    logic signed [CNT_W-1:0] ref_d [N_CH];
    logic signed [CNT_W-1:0] shc_q [N_CH];
    logic signed [CNT_W-1:0] shv_q [N_CH];
    logic [31:0]             shc32 [N_CH];
    logic [31:0]             shv32 [N_CH];
    logic [N_CH-1:0]         she_q;
    logic [N_CH-1:0]         err_live;
    logic [PER_W-1:0]        per_q, per_d;
    logic                    tick;

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        quad_channel #(
            .CNT_W    (CNT_W),
            .FILT_LEN (FILT_LEN)
        ) u_ch (
            .clk     (clk),
            .rst     (reset),
            .a_i     (enc_a[g]),
            .b_i     (enc_b[g]),
            .clear_i (clear[g]),
            .count_o (cnt[g]),
            .err_o   (err_live[g])
        );

        if (CNT_W >= 32) begin : g_trunc
            assign shc32[g] = shc_q[g][31:0];
            assign shv32[g] = shv_q[g][31:0];
        end else begin : g_sext
            assign shc32[g] = {{(32-CNT_W){shc_q[g][CNT_W-1]}}, shc_q[g]};
            assign shv32[g] = {{(32-CNT_W){shv_q[g][CNT_W-1]}}, shv_q[g]};
        end
    end

    assign tick  = (per_q == PER_LAST);
    assign per_d = tick ? '0 : per_q + PER_W'(1);

    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            vel_d[i] = vel_q[i];
            ref_d[i] = ref_q[i];
            if (clear[i]) begin
                vel_d[i] = '0;
                ref_d[i] = '0;
            end else if (tick) begin
                // Modular subtraction keeps the delta correct across count wrap.
                vel_d[i] = cnt[i] - ref_q[i];
                ref_d[i] = cnt[i];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            per_q <= '0;
            she_q <= '0;
            for (int i = 0; i < N_CH; i++) begin
                vel_q[i] <= '0;
                ref_q[i] <= '0;
                shc_q[i] <= '0;
                shv_q[i] <= '0;
            end
        end else begin
            per_q <= per_d;
            for (int i = 0; i < N_CH; i++) begin
                vel_q[i] <= vel_d[i];
                ref_q[i] <= ref_d[i];
            end
            // Shadows take the register values present this cycle, i.e. before
            // any count step or velocity sample landing on the same edge.
            if (snap) begin
                she_q <= err_live;
                for (int i = 0; i < N_CH; i++) begin
                    shc_q[i] <= cnt[i];
                    shv_q[i] <= vel_q[i];
                end
            end
        end
    end

    always_comb begin
        rd_data = 32'h0;
        for (int i = 0; i < N_CH; i++) begin
            if (rd_addr == ADDR_W'(MAP_CNT_BASE + i)) rd_data = shc32[i];
            if (rd_addr == ADDR_W'(map_vel_base(N_CH) + i)) rd_data = shv32[i];
        end
        if (rd_addr == ADDR_W'(map_err_addr(N_CH))) rd_data = 32'(she_q);
        if (rd_addr == ADDR_W'(map_cfg_addr(N_CH))) rd_data = {16'h0, 8'(N_CH), 8'(CNT_W)};
    end

    assign err_flags   = err_live;
    assign sample_tick = tick;

endmodule

// File: tb/tb_quad_encoder_bank.sv
module tb_quad_encoder_bank;

    localparam int N_CH = 4;
    localparam int CNT_W = 8;
    localparam int FILT_LEN = 3;
    localparam int PERIOD_CYC = 100;
    localparam int ADDR_W = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic [N_CH-1:0]   enc_a, enc_b, clear;
    logic              snap;
    logic [ADDR_W-1:0] rd_addr;
    logic [31:0]       rd_data;
    logic [N_CH-1:0]   err_flags;
    logic              sample_tick;

    int n_chk = 0;
    int n_fail = 0;
    int pos [N_CH];

    quad_encoder_bank #(
        .N_CH(N_CH), .CNT_W(CNT_W), .FILT_LEN(FILT_LEN),
        .PERIOD_CYC(PERIOD_CYC), .ADDR_W(ADDR_W)
    ) dut (
        .clk(clk), .reset(reset), .enc_a(enc_a), .enc_b(enc_b), .clear(clear),
        .snap(snap), .rd_addr(rd_addr), .rd_data(rd_data),
        .err_flags(err_flags), .sample_tick(sample_tick)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [1:0] gray(input int p);
        case (p)
            0:       return 2'b00;
            1:       return 2'b01;
            2:       return 2'b11;
            default: return 2'b10;
        endcase
    endfunction

    // Called at a negedge; sets the new AB level then idles gap cycles.
    task automatic move(input int ch, input int dir, input int gap);
        logic [1:0] ab;
        pos[ch] = (pos[ch] + dir + 4) % 4;
        ab = gray(pos[ch]);
        enc_a[ch] = ab[1];
        enc_b[ch] = ab[0];
        repeat (gap) @(negedge clk);
    endtask

    task automatic do_snap();
        snap = 1'b1;
        @(negedge clk);
        snap = 1'b0;
    endtask

    task automatic rd(input int a, output logic [31:0] d);
        rd_addr = ADDR_W'(a);
        #1;
        d = rd_data;
    endtask

    task automatic wait_tick(input int lim, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!sample_tick && n < lim);
        if (!sample_tick) check_eq("tick_timeout", 32'(n), 32'(PERIOD_CYC));
    endtask

    initial begin
        logic [31:0] d;
        int n;

        reset = 1'b1; enc_a = '0; enc_b = '0; clear = '0; snap = 1'b0; rd_addr = '0;
        for (int i = 0; i < N_CH; i++) pos[i] = 0;
        repeat (3) @(negedge clk);
        rd(0, d); check_eq("rst_cnt0", d, 32'h0);
        check_eq("rst_err", 32'(err_flags), 32'h0);
        check_eq("rst_tick", 32'(sample_tick), 32'h0);
        rd(9, d); check_eq("cfg_word", d, 32'h0000_0408);
        rd(12, d); check_eq("unmapped", d, 32'h0);
        reset = 1'b0;
        repeat (12) @(negedge clk);

        // 1) 10 forward cycles on ch0
        for (int k = 0; k < 40; k++) move(0, 1, 20);
        do_snap();
        rd(0, d); check_eq("fwd40", d, 32'd40);
        rd(8, d); check_eq("fwd_err", d, 32'h0);

        // 2) 5 reverse cycles on ch1
        for (int k = 0; k < 20; k++) move(1, -1, 20);
        do_snap();
        rd(1, d); check_eq("rev20", d, 32'hFFFF_FFEC);
        rd(0, d); check_eq("ch0_keep", d, 32'd40);

        // 3) glitch, illegal jump, clear on ch3
        enc_a[3] = 1'b1;
        @(negedge clk);
        enc_a[3] = 1'b0;
        repeat (20) @(negedge clk);
        do_snap();
        rd(3, d); check_eq("glitch", d, 32'h0);
        pos[3] = 2; enc_a[3] = 1'b1; enc_b[3] = 1'b1;
        repeat (20) @(negedge clk);
        do_snap();
        rd(3, d); check_eq("illegal_cnt", d, 32'h0);
        rd(8, d); check_eq("illegal_err", d, 32'h8);
        check_eq("illegal_live", 32'(err_flags), 32'h8);
        clear[3] = 1'b1;
        @(negedge clk);
        clear[3] = 1'b0;
        repeat (10) @(negedge clk);
        check_eq("clr_live", 32'(err_flags), 32'h0);
        do_snap();
        rd(8, d); check_eq("clr_err", d, 32'h0);
        move(3, 1, 20);
        do_snap();
        rd(3, d); check_eq("reprime_11", d, 32'd1);

        // 4) velocity on ch2, 12 steps per period, crossing count wrap
        wait_tick(3 * PERIOD_CYC, n);
        wait_tick(3 * PERIOD_CYC, n);
        check_eq("tick_period", 32'(n), 32'(PERIOD_CYC));
        for (int p = 0; p < 12; p++) begin
            @(negedge clk);
            do_snap();
            if (p > 0) begin
                rd(6, d); check_eq($sformatf("vel_p%0d", p), d, 32'd12);
            end
            for (int k = 0; k < 12; k++) move(2, 1, 7);
            wait_tick(2 * PERIOD_CYC, n);
        end
        @(negedge clk);
        do_snap();
        rd(6, d); check_eq("vel_wrap", d, 32'd12);
        rd(2, d); check_eq("cnt_wrap", d, 32'hFFFF_FF90);

        // 5) snap coincident with a count step on ch0 at 7
        clear[0] = 1'b1;
        @(negedge clk);
        clear[0] = 1'b0;
        repeat (10) @(negedge clk);
        for (int k = 0; k < 7; k++) move(0, 1, 10);
        move(0, 1, 4);
        do_snap();
        rd(0, d); check_eq("snap_pre", d, 32'd7);
        do_snap();
        rd(0, d); check_eq("snap_post", d, 32'd8);

        // 6) illegal on ch1, async reset, priming at 11
        move(1, 2, 20);
        check_eq("err_ch1", 32'(err_flags), 32'h2);
        #3 reset = 1'b1;
        #1;
        check_eq("async_err", 32'(err_flags), 32'h0);
        rd(1, d); check_eq("async_shadow", d, 32'h0);
        pos[0] = 2; enc_a[0] = 1'b1; enc_b[0] = 1'b1;
        repeat (5) @(negedge clk);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        do_snap();
        rd(0, d); check_eq("prime_cnt", d, 32'h0);
        rd(8, d); check_eq("prime_err", d, 32'h0);
        move(0, -1, 20);
        do_snap();
        rd(0, d); check_eq("prime_dec", d, 32'hFFFF_FFFF);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
